// File: rtl/menu_select.sv
// Menu navigation: four debounced buttons drive a MENU/RUN FSM and a frame-synced selection.
// One-cycle press-to-strobe latency after debounce; no backpressure, every event is consumed or dropped.

module menu_select_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic btn_raw,
  output logic press
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_prev_q, level_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    level_prev_d = level_q;
    cnt_d        = '0;
    // Any agreement between the synchronized and debounced levels restarts the stability window.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
    end
  end

  // Rising edge only, so releases and long holds produce no further events.
  assign press = level_q & ~level_prev_q;
endmodule

module menu_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned NUM_OPTIONS     = 3
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       btn_back,
  input  logic       frame_start,
  output logic [1:0] menu_sel,
  output logic       in_menu,
  output logic       start_pulse,
  output logic       back_pulse
);
  typedef enum logic {ST_MENU = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_OPTIONS - 1);

  logic [3:0] raw_btn;
  logic [3:0] press;
  logic       up_evt, down_evt, sel_evt, back_evt;

  assign raw_btn = {btn_back, btn_select, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    menu_select_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_in  (clk_in),
      .reset_in(reset_in),
      .btn_raw (raw_btn[i]),
      .press   (press[i])
    );
  end

  assign up_evt   = press[0];
  assign down_evt = press[1];
  assign sel_evt  = press[2];
  assign back_evt = press[3];

  state_t     state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] menu_sel_q, menu_sel_d;
  logic       start_pulse_q, start_pulse_d;
  logic       back_pulse_q, back_pulse_d;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    menu_sel_d    = menu_sel_q;
    start_pulse_d = 1'b0;
    back_pulse_d  = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (frame_start) begin
          menu_sel_d = pend_q;
        end
        if (sel_evt) begin
          // Launch wins over navigation; the committed index shows at once.
          state_d       = ST_RUN;
          menu_sel_d    = pend_q;
          start_pulse_d = 1'b1;
        end else if (down_evt && !up_evt) begin
          pend_d = (pend_q >= LAST_IDX) ? 2'd0 : pend_q + 2'd1;
        end else if (up_evt && !down_evt) begin
          pend_d = (pend_q == 2'd0) ? LAST_IDX : pend_q - 2'd1;
        end
      end
      ST_RUN: begin
        if (back_evt) begin
          state_d      = ST_MENU;
          back_pulse_d = 1'b1;
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q       <= ST_MENU;
      pend_q        <= 2'd0;
      menu_sel_q    <= 2'd0;
      start_pulse_q <= 1'b0;
      back_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      menu_sel_q    <= menu_sel_d;
      start_pulse_q <= start_pulse_d;
      back_pulse_q  <= back_pulse_d;
    end
  end

  assign menu_sel    = menu_sel_q;
  assign in_menu     = (state_q == ST_MENU);
  assign start_pulse = start_pulse_q;
  assign back_pulse  = back_pulse_q;
endmodule

// File: tb/tb_menu_select.sv
// Directed bench for menu_select with a pulse scoreboard; short debounce window.
module tb_menu_select;
  localparam int DEB = 4;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [3:0] btn_vec;  // {back, select, down, up}
  logic       frame_start;
  logic [1:0] menu_sel;
  logic       in_menu, start_pulse, back_pulse;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       is_start;
    logic [1:0] sel;
    logic       menu;
  } pulse_t;
  pulse_t exp_q[$];

  menu_select #(.DEBOUNCE_CYCLES(DEB), .NUM_OPTIONS(3)) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .btn_up     (btn_vec[0]),
    .btn_down   (btn_vec[1]),
    .btn_select (btn_vec[2]),
    .btn_back   (btn_vec[3]),
    .frame_start(frame_start),
    .menu_sel   (menu_sel),
    .in_menu    (in_menu),
    .start_pulse(start_pulse),
    .back_pulse (back_pulse)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected entry.
  always @(negedge clk_in) begin
    if (!reset_in && (start_pulse || back_pulse)) begin
      check("both_pulses", int'(start_pulse & back_pulse), 0);
      check("pulse_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        pulse_t e;
        e = exp_q.pop_front();
        check("pulse_kind", int'(start_pulse), int'(e.is_start));
        check("pulse_sel", int'(menu_sel), int'(e.sel));
        check("pulse_in_menu", int'(in_menu), int'(e.menu));
      end
    end
  end

  task automatic press(input logic [3:0] mask);
    @(negedge clk_in);
    btn_vec = mask;
    repeat (12) @(negedge clk_in);
    btn_vec = 4'b0000;
    repeat (12) @(negedge clk_in);
  endtask

  task automatic frame();
    @(negedge clk_in);
    frame_start = 1'b1;
    @(negedge clk_in);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  function automatic pulse_t mk(input logic s, input logic [1:0] sel, input logic m);
    pulse_t p;
    p.is_start = s;
    p.sel      = sel;
    p.menu     = m;
    return p;
  endfunction

  initial begin
    reset_in    = 1'b1;
    btn_vec     = 4'b0000;
    frame_start = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_in_menu", int'(in_menu), 1);
    check("rst_sel", int'(menu_sel), 0);
    check("rst_start", int'(start_pulse), 0);
    check("rst_back", int'(back_pulse), 0);
    reset_in = 1'b0;

    // Glitch shorter than the debounce window.
    @(negedge clk_in);
    btn_vec = 4'b0010;
    repeat (3) @(negedge clk_in);
    btn_vec = 4'b0000;
    repeat (20) @(negedge clk_in);
    frame();
    frame();
    check("glitch_sel", int'(menu_sel), 0);

    // Wrap in both directions.
    press(4'b0001);
    check("wrap_no_frame", int'(menu_sel), 0);
    frame();
    check("wrap_up", int'(menu_sel), 2);
    press(4'b0010);
    press(4'b0010);
    frame();
    check("wrap_down", int'(menu_sel), 1);

    // Tear-free update.
    do_reset();
    press(4'b0010);
    repeat (100) @(negedge clk_in);
    check("tear_hold", int'(menu_sel), 0);
    frame();
    check("tear_update", int'(menu_sel), 1);

    // Launch at index 1, navigation ignored in RUN, exit.
    exp_q.push_back(mk(1'b1, 2'd1, 1'b0));
    press(4'b0100);
    check("run_in_menu", int'(in_menu), 0);
    check("run_sel", int'(menu_sel), 1);
    press(4'b0001);
    press(4'b0001);
    frame();
    check("run_up_ignored", int'(menu_sel), 1);
    check("run_still", int'(in_menu), 0);
    exp_q.push_back(mk(1'b0, 2'd1, 1'b1));
    press(4'b1000);
    check("back_in_menu", int'(in_menu), 1);
    press(4'b1000);
    check("menu_back_ignored", int'(in_menu), 1);

    // Simultaneous up/down cancel.
    press(4'b0011);
    frame();
    check("updown_cancel", int'(menu_sel), 1);

    // Select beats a simultaneous down.
    exp_q.push_back(mk(1'b1, 2'd1, 1'b0));
    press(4'b0110);
    check("sel_prio_sel", int'(menu_sel), 1);
    exp_q.push_back(mk(1'b0, 2'd1, 1'b1));
    press(4'b1000);
    frame();
    check("sel_prio_pend", int'(menu_sel), 1);

    // Reset mid-RUN with menu_sel=2.
    press(4'b0001);
    press(4'b0001);
    frame();
    check("pre_rst_sel", int'(menu_sel), 2);
    exp_q.push_back(mk(1'b1, 2'd2, 1'b0));
    press(4'b0100);
    check("pre_rst_run", int'(in_menu), 0);
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    check("runrst_in_menu", int'(in_menu), 1);
    check("runrst_sel", int'(menu_sel), 0);
    check("runrst_pulses", int'(start_pulse | back_pulse), 0);
    reset_in = 1'b0;

    // Button held across reset yields exactly one event after release of reset.
    @(negedge clk_in);
    btn_vec = 4'b0010;
    do_reset();
    repeat (40) @(negedge clk_in);
    frame();
    check("held_rst_sel", int'(menu_sel), 1);
    btn_vec = 4'b0000;
    repeat (12) @(negedge clk_in);
    frame();
    check("held_no_repeat", int'(menu_sel), 1);

    repeat (5) @(negedge clk_in);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
